// File: rtl/spinner_result_reader.sv
// Reads the stopped position of an LED spinner wheel: waits for led_pos to settle
// after a stop request, then publishes position, hit/err flags, score and round count.
module spinner_result_reader #(
  parameter int SETTLE_CYCLES = 50000,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         led_pos,
  input  logic               stop_req,
  input  logic [5:0]         guess,
  output logic               busy,
  output logic               result_valid,
  output logic [2:0]         result_pos,
  output logic               hit,
  output logic               err,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         round_cnt
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_SETTLE = 2'd1,
    REPORT      = 2'd2,
    HOLD        = 2'd3
  } state_t;

  localparam logic [19:0]        SETTLE_LAST = 20'(SETTLE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

  state_t             state_q, state_d;
  logic               stop_meta_q, stop_s_q;
  logic [5:0]         led_prev_q;
  logic [5:0]         guess_l_q, guess_l_d;
  logic [19:0]        stable_cnt_q, stable_cnt_d;
  logic [2:0]         result_pos_q, result_pos_d;
  logic               hit_q, hit_d;
  logic               err_q, err_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         round_cnt_q, round_cnt_d;

  logic               stable;
  logic [2:0]         dec_pos;
  logic [2:0]         ones;
  logic               one_hot;

  assign stable = (led_pos == led_prev_q);

  // Position decode: index of the last set bit plus a population count for the one-hot test.
  always_comb begin
    dec_pos = 3'd0;
    ones    = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (led_pos[i]) begin
        dec_pos = 3'(i);
        ones    = ones + 3'd1;
      end
    end
  end

  assign one_hot = (ones == 3'd1);

  always_comb begin
    state_d      = state_q;
    guess_l_d    = guess_l_q;
    stable_cnt_d = stable_cnt_q;
    result_pos_d = result_pos_q;
    hit_d        = hit_q;
    err_d        = err_q;
    score_d      = score_q;
    round_cnt_d  = round_cnt_q;

    case (state_q)
      IDLE: begin
        if (stop_s_q) begin
          state_d      = WAIT_SETTLE;
          guess_l_d    = guess;
          stable_cnt_d = '0;
        end
      end
      WAIT_SETTLE: begin
        // A released stop request wins over a settle completing on the same cycle.
        if (!stop_s_q) begin
          state_d = IDLE;
        end else if (!stable) begin
          stable_cnt_d = '0;
        end else if (stable_cnt_q == SETTLE_LAST) begin
          state_d      = REPORT;
          result_pos_d = one_hot ? dec_pos : 3'd7;
          err_d        = !one_hot;
          hit_d        = one_hot && guess_l_q[dec_pos];
          if (hit_d && (score_q != SCORE_MAX)) begin
            score_d = score_q + 1'b1;
          end
          round_cnt_d  = round_cnt_q + 8'd1;
        end else begin
          stable_cnt_d = stable_cnt_q + 20'd1;
        end
      end
      REPORT: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!stop_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      stop_meta_q  <= 1'b0;
      stop_s_q     <= 1'b0;
      led_prev_q   <= '0;
      guess_l_q    <= '0;
      stable_cnt_q <= '0;
      result_pos_q <= '0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      score_q      <= '0;
      round_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      stop_meta_q  <= stop_req;
      stop_s_q     <= stop_meta_q;
      led_prev_q   <= led_pos;
      guess_l_q    <= guess_l_d;
      stable_cnt_q <= stable_cnt_d;
      result_pos_q <= result_pos_d;
      hit_q        <= hit_d;
      err_q        <= err_d;
      score_q      <= score_d;
      round_cnt_q  <= round_cnt_d;
    end
  end

  assign busy         = (state_q == WAIT_SETTLE);
  assign result_valid = (state_q == REPORT);
  assign result_pos   = result_pos_q;
  assign hit          = hit_q;
  assign err          = err_q;
  assign score        = score_q;
  assign round_cnt    = round_cnt_q;

endmodule

// File: tb/tb_spinner_result_reader.sv
// Directed and randomized rounds for spinner_result_reader, checked against a
// round-level model of position decode, hit/err, saturating score and round count.
module tb_spinner_result_reader;

  localparam int SC = 8;
  localparam int SW = 4;
  localparam int SCORE_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    led_pos;
  logic          stop_req;
  logic [5:0]    guess;
  logic          busy;
  logic          result_valid;
  logic [2:0]    result_pos;
  logic          hit;
  logic          err;
  logic [SW-1:0] score;
  logic [7:0]    round_cnt;

  int compared   = 0;
  int mismatched = 0;
  int exp_score  = 0;
  int exp_rounds = 0;
  int round_no   = 0;

  spinner_result_reader #(.SETTLE_CYCLES(SC), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .led_pos(led_pos), .stop_req(stop_req), .guess(guess),
    .busy(busy), .result_valid(result_valid), .result_pos(result_pos),
    .hit(hit), .err(err), .score(score), .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] onehot_rand();
    logic [5:0] b;
    b = 6'b000001 << $urandom_range(0, 5);
    return b;
  endfunction

  function automatic logic [5:0] onehot_not(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] x;
    x = onehot_rand();
    while (x == a || x == b) x = onehot_rand();
    return x;
  endfunction

  // Expected {pos[2:0], hit, err} for a stopped wheel value and a latched guess.
  function automatic logic [4:0] expect_res(input logic [5:0] led, input logic [5:0] gl);
    logic [2:0] p;
    if ($countones(led) != 1) return {3'd7, 1'b0, 1'b1};
    p = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (led == (6'b000001 << i)) p = 3'(i);
    end
    return {p, gl[p], 1'b0};
  endfunction

  task automatic run_round(input logic [5:0] g, input logic [5:0] v, input int toggle_after);
    int n;
    logic [4:0] r;
    guess    = g;
    stop_req = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 10) begin tick(); n++; end
    chk("round_busy", 32'(busy), 32'd1);
    guess = ~g;
    repeat ($urandom_range(1, 4)) begin
      led_pos = onehot_not(led_pos, v);
      tick();
      chk("rot_no_valid", 32'(result_valid), 32'd0);
    end
    led_pos = v;
    if (toggle_after > 0) begin
      repeat (toggle_after + 1) begin
        tick();
        chk("pre_toggle_no_valid", 32'(result_valid), 32'd0);
      end
      led_pos = onehot_not(v, v);
      tick();
      chk("toggle_no_valid", 32'(result_valid), 32'd0);
      led_pos = v;
    end
    repeat (SC) begin
      tick();
      chk("settle_no_valid", 32'(result_valid), 32'd0);
      chk("settle_busy", 32'(busy), 32'd1);
    end
    r = expect_res(v, g);
    tick();
    chk("valid_pulse", 32'(result_valid), 32'd1);
    chk("result_pos", 32'(result_pos), 32'(r[4:2]));
    chk("hit", 32'(hit), 32'(r[1]));
    chk("err", 32'(err), 32'(r[0]));
    chk("report_not_busy", 32'(busy), 32'd0);
    if (r[1] && exp_score < SCORE_MAX) exp_score++;
    exp_rounds = (exp_rounds + 1) % 256;
    round_no++;
    $display("round %0d: led=%b guess=%b toggle=%0d pos=%0d hit=%0d err=%0d score=%0d rounds=%0d",
             round_no, v, g, toggle_after, result_pos, hit, err, score, round_cnt);
    tick();
    chk("valid_one_cycle", 32'(result_valid), 32'd0);
    chk("score", 32'(score), 32'(exp_score));
    chk("round_cnt", 32'(round_cnt), 32'(exp_rounds));
    chk("pos_held", 32'(result_pos), 32'(r[4:2]));
    repeat (3) begin
      tick();
      chk("hold_no_valid", 32'(result_valid), 32'd0);
      chk("hold_not_busy", 32'(busy), 32'd0);
    end
    stop_req = 1'b0;
    repeat (4) begin
      tick();
      chk("release_no_valid", 32'(result_valid), 32'd0);
    end
  endtask

  // Stop is released at observation drop_obs after a stable value is driven;
  // drop_obs=6 makes the release land on the very cycle the settle would complete.
  task automatic abort_round(input int drop_obs);
    int n;
    guess    = 6'($urandom_range(0, 63));
    stop_req = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 10) begin tick(); n++; end
    chk("abort_busy", 32'(busy), 32'd1);
    led_pos = onehot_not(led_pos, led_pos);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == drop_obs) stop_req = 1'b0;
      chk("abort_no_valid", 32'(result_valid), 32'd0);
    end
    chk("abort_busy_clear", 32'(busy), 32'd0);
    chk("abort_round_cnt", 32'(round_cnt), 32'(exp_rounds));
    chk("abort_score", 32'(score), 32'(exp_score));
    $display("abort at obs %0d: rounds=%0d score=%0d", drop_obs, round_cnt, score);
  endtask

  initial begin
    int n;
    logic [5:0] v;
    rst = 1'b1; stop_req = 1'b0; led_pos = 6'd0; guess = 6'd0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_pos", 32'(result_pos), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_round_cnt", 32'(round_cnt), 32'd0);
    rst = 1'b0;
    tick();

    run_round(6'b000100, 6'b000100, 0);
    run_round(6'b000000, 6'b100000, 5);
    abort_round(5);
    abort_round(6);
    run_round(6'($urandom_range(0, 63)), 6'b000011, 0);
    run_round(6'b111111, 6'b000000, 0);

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) v = 6'($urandom_range(0, 63));
      else v = onehot_rand();
      run_round(6'($urandom_range(0, 63)), v, int'($urandom_range(0, 6)));
    end

    // Asynchronous reset in the middle of a settle window.
    guess = 6'b111111; stop_req = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 10) begin tick(); n++; end
    chk("mid_rst_busy", 32'(busy), 32'd1);
    led_pos = onehot_not(led_pos, led_pos);
    tick(); tick();
    #3 rst = 1'b1;
    #1;
    exp_score = 0; exp_rounds = 0;
    chk("mid_rst_busy0", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(result_valid), 32'd0);
    chk("mid_rst_pos", 32'(result_pos), 32'd0);
    chk("mid_rst_hit", 32'(hit), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_score", 32'(score), 32'd0);
    chk("mid_rst_round_cnt", 32'(round_cnt), 32'd0);
    repeat (2) begin
      tick();
      chk("in_rst_no_valid", 32'(result_valid), 32'd0);
    end
    rst = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 3) begin tick(); n++; end
    chk("restart_within_3", 32'(busy), 32'd1);
    stop_req = 1'b0;
    repeat (6) begin
      tick();
      chk("post_rst_no_valid", 32'(result_valid), 32'd0);
    end
    chk("post_rst_idle", 32'(busy), 32'd0);
    $display("reset mid-settle: score=%0d rounds=%0d", score, round_cnt);

    for (int i = 0; i < 17; i++) run_round(6'b111111, onehot_rand(), 0);
    chk("sat_score", 32'(score), 32'(SCORE_MAX));
    chk("sat_round_cnt", 32'(round_cnt), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spinner_result_reader.md
SPINNER_RESULT_READER -- requirements
Module: spinner_result_reader

Interface
REQ-001 Parameter SETTLE_CYCLES, default 50000, means consecutive unchanged led_pos cycles that count as a stopped wheel (1 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 Parameter SCORE_W, default 8, means score counter width.
REQ-003 clk  input  1  sole clock, 50 MHz, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 led_pos  input  6  one-hot wheel position from the spinner LED outputs, synchronous to clk.
REQ-006 stop_req  input  1  player stop level, asynchronous to clk, high = stop wheel.
REQ-007 guess  input  6  player guess mask, bit i = guess on position i, synchronous to clk.
REQ-008 busy  output  1  high in WAIT_SETTLE.
REQ-009 result_valid  output  1  one-cycle pulse when a round result is published.
REQ-010 result_pos  output  3  binary index 0..5 of stopped position; 7 = invalid.
REQ-011 hit  output  1  stopped position is in latched guess mask.
REQ-012 err  output  1  stopped led_pos was not one-hot.
REQ-013 score  output  SCORE_W  saturating count of hits.
REQ-014 round_cnt  output  8  count of published results, wraps 255->0.

Function
REQ-015 stop_req SHALL pass a 2-flop synchronizer; all FSM logic uses the synchronized value stop_s.
REQ-016 Block SHALL register led_pos each cycle as led_prev; "stable" means led_pos == led_prev.
REQ-017 FSM states SHALL be IDLE, WAIT_SETTLE, REPORT, HOLD.
REQ-018 IDLE -> WAIT_SETTLE when stop_s is high; on this transition guess is latched into guess_l and stable_cnt cleared.
REQ-019 In WAIT_SETTLE stable_cnt SHALL clear on any cycle led_pos != led_prev and increment otherwise.
REQ-020 WAIT_SETTLE -> REPORT on the cycle stable_cnt reaches SETTLE_CYCLES-1 while stable; stable_cnt SHALL not exceed that value.
REQ-021 WAIT_SETTLE -> IDLE when stop_s falls before REPORT; no result published, round_cnt, score and result outputs unchanged.
REQ-022 If stop_s falls on the same cycle settle completes, abort (REQ-021) SHALL take priority.
REQ-023 REPORT SHALL last exactly one cycle with result_valid=1, then go to HOLD.
REQ-024 On entering REPORT, result_pos, hit, err SHALL be registered from led_pos and guess_l and held until the next REPORT.
REQ-025 Valid one-hot led_pos: result_pos = index of set bit, err=0, hit = guess_l[index].
REQ-026 Non-one-hot led_pos (zero or multiple bits): result_pos=7, err=1, hit=0.
REQ-027 score SHALL increment by 1 in REPORT when hit=1, saturating at 2^SCORE_W-1.
REQ-028 round_cnt SHALL increment by 1 in every REPORT including err results, wrapping 255->0.
REQ-029 HOLD -> IDLE when stop_s is low; no new round until then.
REQ-030 guess changes after latching SHALL not affect the current round.
REQ-031 guess_l = 6'b000000 yields hit=0; guess_l = 6'b111111 yields hit=1 for every valid position.

Reset
REQ-032 rst high SHALL immediately force state IDLE, synchronizer flops 0, led_prev 0, stable_cnt 0, guess_l 0.
REQ-033 Reset values: busy=0, result_valid=0, result_pos=0, hit=0, err=0, score=0, round_cnt=0.
REQ-034 rst asserted mid-WAIT_SETTLE or mid-REPORT SHALL discard the round with no result_valid pulse.
REQ-035 After rst falls with stop_req already high, a round SHALL start within 3 cycles (synchronizer latency).

Verification (SETTLE_CYCLES=8, SCORE_W=4)
REQ-036 led_pos rotating every cycle, stop_req=1, guess=6'b000100, then led_pos held 6'b000100 -> result_valid one cycle exactly 8 stable cycles after hold begins, result_pos=2, hit=1, score=1, round_cnt=1.
REQ-037 Hold led_pos=6'b100000 with guess=0 but toggle led_pos once after 5 stable cycles -> counter restarts, result_valid after 8 further stable cycles, result_pos=5, hit=0, score unchanged.
REQ-038 stop_req high then low after 4 stable cycles -> no result_valid, busy returns 0, round_cnt unchanged.
REQ-039 led_pos=6'b000011 held stable with stop_req=1 -> result_valid, result_pos=7, err=1, hit=0, round_cnt increments, score unchanged.
REQ-040 17 consecutive hit rounds with guess=6'b111111 -> score saturates at 15; round_cnt=17.
REQ-041 rst pulsed during WAIT_SETTLE -> all outputs return to reset values immediately, no result_valid pulse.
